// File: rtl/cli_cmd_parser.sv
// ASCII "<dec> <op> <dec><CR|LF>" line parser feeding the 32-bit ALU stage.
// Presents OperA/OperB/OpCode with a valid/ready handshake; malformed lines are flagged and dropped.
module cli_cmd_parser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic [31:0] OperA,
  output logic [31:0] OperB,
  output logic [1:0]  OpCode,
  output logic        CmdValid,
  input  logic        CmdReady,
  output logic        Busy,
  output logic        ErrPulse
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned MAX_DIGITS = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_NUM_A, S_WAIT_OP, S_WAIT_B, S_NUM_B, S_WAIT_END, S_HOLD, S_SKIP
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   oper_a_q, oper_a_d, oper_b_q, oper_b_d;
  logic [1:0]          opcode_q, opcode_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                is_digit, is_space, is_term, is_op, cnt_full;
  logic [1:0]          op_code;
  logic [DATA_W-1:0]   digit, acc_a, acc_b;

  // Byte classification and decimal accumulate (x*10 as shift-add, wraps mod 2^32)
  always_comb begin
    is_digit = (RxData >= 8'h30) && (RxData <= 8'h39);
    is_space = (RxData == 8'h20);
    is_term  = (RxData == 8'h0D) || (RxData == 8'h0A);
    is_op    = 1'b1;
    op_code  = 2'b00;
    case (RxData)
      8'h2B:   op_code = 2'b00;
      8'h2D:   op_code = 2'b01;
      8'h26:   op_code = 2'b10;
      8'h7C:   op_code = 2'b11;
      default: is_op   = 1'b0;
    endcase
    digit    = {28'd0, RxData[3:0]};
    acc_a    = (a_q << 3) + (a_q << 1) + digit;
    acc_b    = (b_q << 3) + (b_q << 1) + digit;
    cnt_full = (cnt_q == CNT_W'(MAX_DIGITS));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    oper_a_d    = oper_a_q;
    oper_b_d    = oper_b_q;
    opcode_d    = opcode_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: if (RxValid) begin
        if (is_digit) begin
          state_d = S_NUM_A;
          a_d     = digit;
          cnt_d   = CNT_W'(1);
        end else if (!(is_space || is_term)) begin
          err_d   = 1'b1;
          state_d = S_SKIP;
        end
      end
      S_NUM_A: if (RxValid) begin
        if (is_digit && !cnt_full) begin
          a_d   = acc_a;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (is_space) begin
          state_d = S_WAIT_OP;
        end else if (is_op) begin
          state_d = S_WAIT_B;
          op_d    = op_code;
        end else begin
          err_d   = 1'b1;
          state_d = is_term ? S_IDLE : S_SKIP;
        end
      end
      S_WAIT_OP: if (RxValid) begin
        if (is_op) begin
          state_d = S_WAIT_B;
          op_d    = op_code;
        end else if (!is_space) begin
          err_d   = 1'b1;
          state_d = is_term ? S_IDLE : S_SKIP;
        end
      end
      S_WAIT_B: if (RxValid) begin
        if (is_digit) begin
          state_d = S_NUM_B;
          b_d     = digit;
          cnt_d   = CNT_W'(1);
        end else if (!is_space) begin
          err_d   = 1'b1;
          state_d = is_term ? S_IDLE : S_SKIP;
        end
      end
      S_NUM_B: if (RxValid) begin
        if (is_digit && !cnt_full) begin
          b_d   = acc_b;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (is_space) begin
          state_d = S_WAIT_END;
        end else if (is_term) begin
          state_d = S_HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = S_SKIP;
        end
      end
      S_WAIT_END: if (RxValid) begin
        if (is_term) begin
          state_d = S_HOLD;
        end else if (!is_space) begin
          err_d   = 1'b1;
          state_d = S_SKIP;
        end
      end
      S_HOLD: begin
        err_d = RxValid;
        if (CmdReady) state_d = S_IDLE;
      end
      S_SKIP: if (RxValid && is_term) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output operands are captured only on entry to HOLD
    if ((state_q != S_HOLD) && (state_d == S_HOLD)) begin
      oper_a_d = a_q;
      oper_b_d = b_q;
      opcode_d = op_q;
    end
    cmd_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      oper_a_q    <= '0;
      oper_b_q    <= '0;
      opcode_q    <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      oper_a_q    <= oper_a_d;
      oper_b_q    <= oper_b_d;
      opcode_q    <= opcode_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign OperA    = oper_a_q;
  assign OperB    = oper_b_q;
  assign OpCode   = opcode_q;
  assign CmdValid = cmd_valid_q;
  assign Busy     = busy_q;
  assign ErrPulse = err_q;

endmodule

// File: tb/tb_cli_cmd_parser.sv
// Bench for cli_cmd_parser: line-level reference model feeds an expected-command queue,
// a negedge monitor pops and compares on every handshake and counts error pulses.
module tb_cli_cmd_parser;

  typedef logic [7:0] u8;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } cmd_t;

  localparam u8 CR = 8'h0D;
  localparam u8 LF = 8'h0A;

  logic        clk, rst_n;
  logic [7:0]  RxData;
  logic        RxValid;
  logic [31:0] OperA, OperB;
  logic [1:0]  OpCode;
  logic        CmdValid, CmdReady, Busy, ErrPulse;

  cli_cmd_parser dut (
    .clk(clk), .rst_n(rst_n), .RxData(RxData), .RxValid(RxValid),
    .OperA(OperA), .OperB(OperB), .OpCode(OpCode), .CmdValid(CmdValid),
    .CmdReady(CmdReady), .Busy(Busy), .ErrPulse(ErrPulse)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  bit   rdy_rand = 0;
  bit   gap_en = 0;
  cmd_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  // Random backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) CmdReady = ($urandom_range(0, 1) == 1);
  end

  function automatic bit is_dig(input u8 c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Line-level reference: a line is a command iff it matches
  // sp* D{1,10} sp* op sp* D{1,10} sp* term; blank lines are ignored; anything else is one error.
  function automatic void model_line(input u8 ln[$], output bit is_cmd, output bit is_err,
                                     output cmd_t c);
    int          i, n, nd;
    longint      v;
    is_cmd = 0;
    is_err = 0;
    c      = '{32'd0, 32'd0, 2'd0};
    n = ln.size() - 1;
    i = 0;
    while (i < n && ln[i] == 8'h20) i++;
    if (i == n) return;
    nd = 0; v = 0;
    while (i < n && is_dig(ln[i])) begin
      v = (v * 10 + longint'(ln[i] - 8'h30)) % 64'd4294967296; nd++; i++;
    end
    if (nd == 0 || nd > 10) begin is_err = 1; return; end
    c.a = v[31:0];
    while (i < n && ln[i] == 8'h20) i++;
    if (i >= n) begin is_err = 1; return; end
    case (ln[i])
      8'h2B: c.op = 2'd0;
      8'h2D: c.op = 2'd1;
      8'h26: c.op = 2'd2;
      8'h7C: c.op = 2'd3;
      default: begin is_err = 1; return; end
    endcase
    i++;
    while (i < n && ln[i] == 8'h20) i++;
    nd = 0; v = 0;
    while (i < n && is_dig(ln[i])) begin
      v = (v * 10 + longint'(ln[i] - 8'h30)) % 64'd4294967296; nd++; i++;
    end
    if (nd == 0 || nd > 10) begin is_err = 1; return; end
    c.b = v[31:0];
    while (i < n && ln[i] == 8'h20) i++;
    if (i != n) begin is_err = 1; return; end
    is_cmd = 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input u8 b);
    RxData  = b;
    RxValid = 1'b1;
    tick();
    RxValid = 1'b0;
    RxData  = 8'h00;
    if (gap_en) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic run_line(input u8 ln[$], input bit hold_poke);
    bit   is_cmd, is_err;
    cmd_t c;
    int   t;
    model_line(ln, is_cmd, is_err, c);
    if (is_cmd) exp_q.push_back(c);
    if (is_err) err_exp++;
    for (int i = 0; i < ln.size(); i++) begin
      RxData  = ln[i];
      RxValid = 1'b1;
      tick();
      RxValid = 1'b0;
      if (gap_en && i != ln.size() - 1) repeat ($urandom_range(0, 2)) tick();
    end
    if (is_cmd) begin
      n_cmp++;
      if (CmdValid !== 1'b1) begin
        n_bad++;
        $display("FAIL latency: CmdValid=%b one cycle after terminator, need 1", CmdValid);
      end
      if (hold_poke) begin
        send_byte(8'h39);
        err_exp++;
      end
      t = 0;
      while (Busy && t < 300) begin tick(); t++; end
      if (t >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL hold_timeout: Busy still %b after %0d cycles, need 0", Busy, t);
      end
    end
    tick();
    tick();
    n_cmp++;
    if (!is_cmd && CmdValid) begin
      n_bad++;
      $display("FAIL spurious_cmd: CmdValid=%b after non-command line, need 0", CmdValid);
    end else if (err_seen != err_exp) begin
      n_bad++;
      $display("FAIL err_count: ErrPulse count %0d, need %0d", err_seen, err_exp);
      err_seen = err_exp;
    end
  endtask

  task automatic run_str(input string s, input u8 term, input bit hold_poke);
    u8 q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    q.push_back(term);
    run_line(q, hold_poke);
  endtask

  function automatic u8 rnd_digit();
    return u8'(8'h30 + 8'($urandom_range(0, 9)));
  endfunction

  task automatic add_num(inout u8 q[$]);
    int r, len;
    r = $urandom_range(0, 9);
    if (r == 1) begin
      string s;
      s = ($urandom_range(0, 1) == 1) ? "4294967295" : "4294967296";
      for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    end else begin
      len = (r == 0) ? 11 : $urandom_range(1, 10);
      for (int i = 0; i < len; i++) q.push_back(rnd_digit());
    end
  endtask

  task automatic add_sp(inout u8 q[$], input int mx);
    repeat ($urandom_range(0, mx)) q.push_back(8'h20);
  endtask

  task automatic gen_line(output u8 q[$]);
    u8 ops[4];
    u8 b;
    int pos;
    ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h26; ops[3] = 8'h7C;
    q.delete();
    add_sp(q, 2);
    if ($urandom_range(0, 9) != 0) begin
      add_num(q);
      add_sp(q, 1);
      q.push_back(ops[$urandom_range(0, 3)]);
      add_sp(q, 1);
      add_num(q);
      add_sp(q, 1);
      if ($urandom_range(0, 4) == 0) begin
        do b = u8'($urandom_range(0, 255)); while (b == CR || b == LF);
        pos = $urandom_range(0, q.size() - 1);
        q[pos] = b;
      end
    end
    q.push_back(($urandom_range(0, 1) == 1) ? CR : LF);
  endtask

  // Monitor: counts error pulses, pops expected commands on handshake, checks stability
  initial begin
    bit          chk_low, hold_prev;
    logic [31:0] pa, pb;
    logic [1:0]  po;
    cmd_t        c;
    chk_low = 0; hold_prev = 0; pa = 0; pb = 0; po = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_low = 0; hold_prev = 0;
      end else begin
        if (ErrPulse) err_seen++;
        n_cmp++;
        if (Busy !== CmdValid) begin
          n_bad++;
          $display("FAIL busy_match: Busy=%b, need CmdValid=%b", Busy, CmdValid);
        end
        if (chk_low) begin
          n_cmp++;
          if (CmdValid) begin
            n_bad++;
            $display("FAIL post_transfer: CmdValid=%b after transfer, need 0", CmdValid);
          end
        end
        chk_low = 0;
        if (CmdValid) begin
          if (hold_prev) begin
            n_cmp++;
            if (OperA !== pa || OperB !== pb || OpCode !== po) begin
              n_bad++;
              $display("FAIL stable: A=%0d B=%0d op=%0d, need A=%0d B=%0d op=%0d",
                       OperA, OperB, OpCode, pa, pb, po);
            end
          end
          if (CmdReady) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL unexpected_cmd: A=%0d B=%0d op=%0d, need no command",
                       OperA, OperB, OpCode);
            end else begin
              c = exp_q.pop_front();
              if (OperA !== c.a || OperB !== c.b || OpCode !== c.op) begin
                n_bad++;
                $display("FAIL cmd: A=%0d B=%0d op=%0d, need A=%0d B=%0d op=%0d",
                         OperA, OperB, OpCode, c.a, c.b, c.op);
              end
            end
            chk_low = 1; hold_prev = 0;
          end else begin
            hold_prev = 1; pa = OperA; pb = OperB; po = OpCode;
          end
        end else begin
          hold_prev = 0;
        end
      end
    end
  end

  initial begin
    u8 q[$];
    rst_n = 1'b0; RxValid = 1'b0; RxData = 8'h00; CmdReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({OperA, OperB, OpCode, CmdValid, Busy, ErrPulse} !== '0) begin
      n_bad++;
      $display("FAIL reset: A=%0d B=%0d op=%0d v=%b busy=%b err=%b, need all 0",
               OperA, OperB, OpCode, CmdValid, Busy, ErrPulse);
    end

    CmdReady = 1'b1;
    run_str("2+2", CR, 0);
    run_str(" 123 - 45 ", LF, 0);
    run_str("4294967295&1", CR, 0);
    run_str("4294967296|0", CR, 0);
    run_str("12345678901+1", CR, 0);
    run_str("5+3", CR, 0);
    run_str("7x", CR, 0);
    run_str("   ", LF, 0);

    // Backpressure with a dropped byte during HOLD
    CmdReady = 1'b0;
    exp_q.push_back('{32'd8, 32'd7, 2'd0});
    send_byte(8'h38); send_byte(8'h2B); send_byte(8'h37); send_byte(CR);
    repeat (3) tick();
    n_cmp++;
    if (!CmdValid || !Busy || OperA !== 32'd8 || OperB !== 32'd7) begin
      n_bad++;
      $display("FAIL hold: v=%b busy=%b A=%0d B=%0d, need v=1 busy=1 A=8 B=7",
               CmdValid, Busy, OperA, OperB);
    end
    send_byte(8'h39);
    err_exp++;
    n_cmp++;
    if (!ErrPulse || !CmdValid || OperA !== 32'd8 || OperB !== 32'd7) begin
      n_bad++;
      $display("FAIL hold_drop: err=%b v=%b A=%0d B=%0d, need err=1 v=1 A=8 B=7",
               ErrPulse, CmdValid, OperA, OperB);
    end
    CmdReady = 1'b1;
    tick();
    CmdReady = 1'b0;
    n_cmp++;
    if (CmdValid) begin
      n_bad++;
      $display("FAIL release: CmdValid=%b after one-cycle ready, need 0", CmdValid);
    end
    tick();

    // Reset mid-line
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h2B);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({OperA, OperB, OpCode, CmdValid, Busy, ErrPulse} !== '0) begin
      n_bad++;
      $display("FAIL midline_reset: A=%0d B=%0d op=%0d v=%b, need all 0",
               OperA, OperB, OpCode, CmdValid);
    end
    CmdReady = 1'b1;
    run_str("5+3", CR, 0);

    // Randomized lines with random gaps, backpressure and HOLD pokes
    rdy_rand = 1;
    gap_en   = 1;
    for (int k = 0; k < 80; k++) begin
      gen_line(q);
      run_line(q, $urandom_range(0, 3) == 0);
    end
    rdy_rand = 0;
    gap_en   = 0;
    CmdReady = 1'b1;
    repeat (4) tick();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d commands never delivered, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cli_cmd_parser.md
# cli_cmd_parser

ASCII command parser that sits directly upstream of the 32-bit `Add` ALU stage in the command-line interface. It consumes received bytes (one strobe per byte), parses lines of the form `<decimal> <op> <decimal><CR|LF>`, and presents `OperA`, `OperB` and an opcode to the ALU with a valid/ready handshake. Malformed lines are discarded and flagged.

## Interface
No parameters.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `RxData` in 8: received ASCII byte.
- `RxValid` in 1: `RxData` is valid this cycle, one cycle per byte.
- `OperA` out 32: first operand, registered.
- `OperB` out 32: second operand, registered.
- `OpCode` out 2: operation; `00` is `+`, `01` is `-`, `10` is `&`, `11` is `|`.
- `CmdValid` out 1: command available; held until accepted.
- `CmdReady` in 1: downstream accepts the command.
- `Busy` out 1: high in HOLD; incoming bytes are dropped.
- `ErrPulse` out 1: one-cycle syntax or overrun error flag.

## Operation
- Character classes:
  - digit: `0x30`–`0x39`
  - space: `0x20`
  - terminator: CR `0x0D` or LF `0x0A`
  - op: `+` `-` `&` `|`
  - other: any remaining byte
- The FSM advances only on cycles with `RxValid=1`, except HOLD, which also responds to `CmdReady`.
- States and transitions:
  - IDLE:
    - digit → NUM_A; A=d, cnt=1.
    - space or terminator → stay.
    - op or other → error, SKIP.
  - NUM_A:
    - digit → A=A*10+d, cnt+1. If cnt is already 10, this is an error → SKIP.
    - space → WAIT_OP.
    - op → WAIT_B; latch opcode.
    - terminator → error, IDLE.
    - other → error, SKIP.
  - WAIT_OP:
    - space → stay.
    - op → WAIT_B; latch opcode.
    - terminator → error, IDLE.
    - digit or other → error, SKIP.
  - WAIT_B:
    - space → stay.
    - digit → NUM_B; B=d, cnt=1.
    - terminator → error, IDLE.
    - op or other → error, SKIP.
  - NUM_B:
    - digit → accumulate as in NUM_A, with the same 10-digit limit.
    - space → WAIT_END.
    - terminator → HOLD.
    - op or other → error, SKIP.
  - WAIT_END:
    - space → stay.
    - terminator → HOLD.
    - anything else → error, SKIP.
  - HOLD:
    - `CmdValid=1`, `Busy=1`.
    - `CmdReady=1` → IDLE.
    - Any `RxValid` byte is discarded and pulses `ErrPulse`. State is unchanged unless `CmdReady` is also high.
  - SKIP:
    - discard bytes; terminator → IDLE. No further `ErrPulse`.
- Error means `ErrPulse=1` for exactly one cycle, in the cycle after the offending byte.
- Arithmetic:
  - A*10 is computed as (A<<3)+(A<<1), truncated to 32 bits.
  - Values wrap modulo 2^32.
  - More than 10 digits in one operand is an error.
  - Leading zeros count toward the 10 digits.
- Working registers for A and B are separate from the output registers. `OperA`, `OperB` and `OpCode` update only on entry to HOLD and hold their values otherwise.
- An empty line (terminator only, in IDLE) is ignored. It produces no error.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - working registers and digit counter 0
- Reset mid-line discards all partial state. Output operands return to 0.
- Latency: `CmdValid` rises in the cycle after the terminator byte is sampled. `OperA`, `OperB` and `OpCode` are valid in that same cycle.
- Handshake:
  - Transfer occurs on a cycle where `CmdValid` and `CmdReady` are both 1.
  - `CmdValid` is 0 in the following cycle.
  - If `CmdReady` is held high, `CmdValid` is a one-cycle pulse.
  - Operands stay stable while `CmdValid=1`.
- Simultaneous `CmdReady=1` and `RxValid=1` in HOLD: the command transfers, the byte is dropped, and `ErrPulse` is asserted.
- Back-to-back bytes with `RxValid` high on every cycle are supported in all states.
- The first byte after leaving HOLD can arrive in the very next cycle and is parsed from IDLE.

## Test plan
- Line "2+2\r" with `CmdReady=1` → one-cycle `CmdValid`, `OperA=2`, `OperB=2`, `OpCode=00`, no `ErrPulse`.
- Line " 123 - 45 \n" → `OperA=123`, `OperB=45`, `OpCode=01`.
- Wrap-around:
  - "4294967295&1\r" → `OperA=0xFFFFFFFF`, `OperB=1`, `OpCode=10`.
  - "4294967296|0\r" → `OperA=0`, `OpCode=11`.
- Overrun and garbage:
  - "12345678901+1\r" → `ErrPulse` one cycle after the 11th digit, no `CmdValid`.
  - Then "5+3\r" → `OperA=5`, `OperB=3`.
  - "7x\r" → `ErrPulse` once, no `CmdValid`.
- Backpressure: `CmdReady=0`, send "8+7\r" → `CmdValid` and `Busy` held with `OperA=8`, `OperB=7`.
  - Byte '9' during HOLD → `ErrPulse`, outputs unchanged.
  - `CmdReady=1` for one cycle → `CmdValid` 0 on the next cycle.
- Reset mid-line: send "12+", then `rst_n=0` for one cycle → all outputs 0.
  - Then "5+3\r" → `OperA=5`, `OperB=3`, `OpCode=00`.
